// File: rtl/crc_stream_pkg.sv
`default_nettype none
// =============================================================================
// Module   : crc_stream_pkg
// Desc     : Shared types and helpers for the crc_stream block (length type,
//            saturation limit, last-beat keep counting).
// Rev      : 1.0  initial release
// =============================================================================
package crc_stream_pkg;

   typedef logic [15:0] len_t;
   typedef logic [7:0]  cnt_t;

   localparam len_t LEN_MAX  = 16'hffff;
   localparam int   KEEP_MAX = 128;

   // Leading run of ones from bit 0; anything past the first zero is ignored.
   function automatic cnt_t keep_count(input logic [KEEP_MAX-1:0] keep, input int nbytes);
      cnt_t cnt;
      logic run;
      cnt = '0;
      run = 1'b1;
      for (int i = 0; i < KEEP_MAX; i++) begin
         if (run && (i < nbytes) && keep[i]) begin
            cnt = cnt + 8'd1;
         end else begin
            run = 1'b0;
         end
      end
      return cnt;
   endfunction

   function automatic len_t sat_add(input len_t a, input cnt_t b);
      logic [16:0] sum;
      sum = {1'b0, a} + {9'b0, b};
      return (sum > {1'b0, LEN_MAX}) ? LEN_MAX : sum[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc_stream_if.sv
`default_nettype none
// =============================================================================
// Module   : crc_stream_if
// Desc     : Byte-stream input and per-packet result channel of crc_stream.
//            m_ok exists only when CRC_STREAM_CHECK_EN is defined.
// Rev      : 1.0  initial release
// =============================================================================
interface crc_stream_if
   import crc_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CRC_WIDTH  = 32
);
   localparam int c_bytes = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] s_data;
   logic [c_bytes-1:0]    s_keep;
   logic                  s_last;
   logic                  s_valid;
   logic                  s_ready;
   logic [CRC_WIDTH-1:0]  m_crc;
   len_t                  m_len;
`ifdef CRC_STREAM_CHECK_EN
   logic                  m_ok;
`endif
   logic                  m_valid;
   logic                  m_ready;

`ifdef CRC_STREAM_CHECK_EN
   modport master (
      output s_data, s_keep, s_last, s_valid, m_ready,
      input  s_ready, m_crc, m_len, m_ok, m_valid
   );
   modport slave (
      input  s_data, s_keep, s_last, s_valid, m_ready,
      output s_ready, m_crc, m_len, m_ok, m_valid
   );
`else
   modport master (
      output s_data, s_keep, s_last, s_valid, m_ready,
      input  s_ready, m_crc, m_len, m_valid
   );
   modport slave (
      input  s_data, s_keep, s_last, s_valid, m_ready,
      output s_ready, m_crc, m_len, m_valid
   );
`endif

endinterface
`default_nettype wire

// File: rtl/crc_byte_step.sv
`default_nettype none
// =============================================================================
// Module   : crc_byte_step
// Desc     : Combinational 8-bit parallel Galois LFSR step, MSB-first or
//            reflected (LSB-first) according to REVERSE.
// Rev      : 1.0  initial release
// =============================================================================
module crc_byte_step #(
   parameter int                   CRC_WIDTH = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04c11db7,
   parameter bit                   REVERSE   = 1'b1
) (
   input  logic [CRC_WIDTH-1:0] i_crc,
   input  logic [7:0]           i_data,
   output logic [CRC_WIDTH-1:0] o_crc
);

   function automatic logic [CRC_WIDTH-1:0] reflect_poly(input logic [CRC_WIDTH-1:0] v);
      logic [CRC_WIDTH-1:0] r;
      for (int i = 0; i < CRC_WIDTH; i++) begin
         r[i] = v[CRC_WIDTH-1-i];
      end
      return r;
   endfunction

   generate
      if (REVERSE) begin : g_reflected
         localparam logic [CRC_WIDTH-1:0] c_poly_refl = reflect_poly(CRC_POLY);
         logic [CRC_WIDTH-1:0] w_acc;
         logic                 w_fb;

         always_comb begin
            w_acc = i_crc;
            w_fb  = 1'b0;
            for (int i = 0; i < 8; i++) begin
               w_fb  = w_acc[0] ^ i_data[i];
               w_acc = w_acc >> 1;
               if (w_fb) begin
                  w_acc = w_acc ^ c_poly_refl;
               end
            end
            o_crc = w_acc;
         end
      end else begin : g_normal
         logic [CRC_WIDTH-1:0] w_acc;
         logic                 w_fb;

         always_comb begin
            w_acc = i_crc;
            w_fb  = 1'b0;
            for (int i = 7; i >= 0; i--) begin
               w_fb  = w_acc[CRC_WIDTH-1] ^ i_data[i];
               w_acc = w_acc << 1;
               if (w_fb) begin
                  w_acc = w_acc ^ CRC_POLY;
               end
            end
            o_crc = w_acc;
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/crc_stream.sv
`default_nettype none
// =============================================================================
// Module   : crc_stream
// Desc     : Packet-aware streaming CRC engine with last-beat byte masking,
//            final XOR and saturating length. CRC_STREAM_CHECK_EN adds m_ok.
// Rev      : 1.0  initial release
// =============================================================================
module crc_stream
   import crc_stream_pkg::*;
#(
   parameter int                   DATA_WIDTH = 64,
   parameter int                   CRC_WIDTH  = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY   = 32'h04c11db7,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT   = 32'hffffffff,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT    = 32'hffffffff,
   parameter bit                   REVERSE    = 1'b1,
   parameter logic [CRC_WIDTH-1:0] RESIDUE    = 32'hdebb20e3
) (
   input  logic          clk,
   input  logic          rst_n,
   crc_stream_if.slave   bus
);

   localparam int   c_bytes     = DATA_WIDTH / 8;
   localparam cnt_t c_bytes_cnt = cnt_t'(c_bytes);

   logic [CRC_WIDTH-1:0] r_crc;
   len_t                 r_len;
   logic [CRC_WIDTH-1:0] r_m_crc;
   len_t                 r_m_len;
   logic                 r_m_valid;

   logic [CRC_WIDTH-1:0] w_lane_crc [0:c_bytes];
   logic [CRC_WIDTH-1:0] w_last_crc;
   logic [KEEP_MAX-1:0]  w_keep_ext;
   cnt_t                 w_k;
   logic                 w_accept;

   assign bus.s_ready = !r_m_valid || bus.m_ready;
   assign w_accept    = bus.s_valid && bus.s_ready;

   // Lane i's tap holds the register after lanes 0..i-1 have been folded in.
   assign w_lane_crc[0] = r_crc;

   generate
      for (genvar g = 0; g < c_bytes; g++) begin : g_lane
         crc_byte_step #(
            .CRC_WIDTH (CRC_WIDTH),
            .CRC_POLY  (CRC_POLY),
            .REVERSE   (REVERSE)
         ) u_step (
            .i_crc  (w_lane_crc[g]),
            .i_data (bus.s_data[8*g +: 8]),
            .o_crc  (w_lane_crc[g+1])
         );
      end
   endgenerate

   always_comb begin
      w_keep_ext              = '0;
      w_keep_ext[c_bytes-1:0] = bus.s_keep;
   end

   assign w_k = keep_count(w_keep_ext, c_bytes);

   always_comb begin
      w_last_crc = w_lane_crc[0];
      for (int i = 1; i <= c_bytes; i++) begin
         if (w_k == cnt_t'(i)) begin
            w_last_crc = w_lane_crc[i];
         end
      end
   end

`ifdef CRC_STREAM_CHECK_EN
   logic r_m_ok;
   assign bus.m_ok = r_m_ok;
`else
   logic w_unused_residue;
   assign w_unused_residue = ^RESIDUE;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc     <= CRC_INIT;
         r_len     <= '0;
         r_m_crc   <= '0;
         r_m_len   <= '0;
         r_m_valid <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
         r_m_ok    <= 1'b0;
`endif
      end else begin
         if (w_accept && bus.s_last) begin
            r_crc     <= CRC_INIT;
            r_len     <= '0;
            r_m_crc   <= w_last_crc ^ XOR_OUT;
            r_m_len   <= sat_add(r_len, w_k);
            r_m_valid <= 1'b1;
`ifdef CRC_STREAM_CHECK_EN
            r_m_ok    <= (w_last_crc == RESIDUE);
`endif
         end else begin
            if (w_accept) begin
               r_crc <= w_lane_crc[c_bytes];
               r_len <= sat_add(r_len, c_bytes_cnt);
            end
            if (bus.m_ready) begin
               r_m_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.m_crc   = r_m_crc;
   assign bus.m_len   = r_m_len;
   assign bus.m_valid = r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_crc_stream.sv
`default_nettype none
// =============================================================================
// Module   : tb_crc_stream
// Desc     : Self-checking bench for crc_stream against a bytewise CRC-32
//            reference model; m_ok checks apply when CRC_STREAM_CHECK_EN is set.
// Rev      : 1.0  initial release
// =============================================================================
module tb_crc_stream;
   import crc_stream_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   crc_stream_if #(.DATA_WIDTH(64), .CRC_WIDTH(32)) bus ();

   crc_stream #(
      .DATA_WIDTH (64),
      .CRC_WIDTH  (32),
      .CRC_POLY   (32'h04c11db7),
      .CRC_INIT   (32'hffffffff),
      .XOR_OUT    (32'hffffffff),
      .REVERSE    (1'b1),
      .RESIDUE    (32'hdebb20e3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] crc;
      logic [15:0] len;
      logic        ok;
   } exp_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   bit          rand_ready = 1'b0;
   logic [7:0]  cur_q[$];
   exp_t        exp_q[$];
   bit          hold = 1'b0;
   logic [31:0] hold_crc;
   logic [15:0] hold_len;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reflected CRC-32 register value over a byte sequence, before final XOR.
   function automatic logic [31:0] ref_reg(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hffffffff;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] exp_crc(input logic [63:0] d, input int k);
      logic [7:0] q[$];
      for (int i = 0; i < k; i++) q.push_back(d[8*i +: 8]);
      return ref_reg(q) ^ 32'hffffffff;
   endfunction

   always @(negedge clk) begin : mon
      int   k;
      exp_t e;
      logic [31:0] r;
      if (!rst_n) begin
         cur_q.delete();
         hold = 1'b0;
      end else begin
         check("s_ready_rule", 64'(bus.s_ready), 64'(!bus.m_valid || bus.m_ready));
         if (hold) begin
            check("hold_m_valid", 64'(bus.m_valid), 64'(1));
            check("hold_m_crc", 64'(bus.m_crc), 64'(hold_crc));
            check("hold_m_len", 64'(bus.m_len), 64'(hold_len));
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 64'(0), 64'(1));
            end else begin
               e = exp_q.pop_front();
               check("m_crc", 64'(bus.m_crc), 64'(e.crc));
               check("m_len", 64'(bus.m_len), 64'(e.len));
`ifdef CRC_STREAM_CHECK_EN
               check("m_ok", 64'(bus.m_ok), 64'(e.ok));
`endif
            end
         end
         hold     = bus.m_valid && !bus.m_ready;
         hold_crc = bus.m_crc;
         hold_len = bus.m_len;
         if (bus.s_valid && bus.s_ready) begin
            k = 0;
            for (int i = 0; i < 8; i++) begin
               if (bus.s_keep[i]) k++;
               else break;
            end
            for (int i = 0; i < 8; i++) begin
               if (!bus.s_last || i < k) cur_q.push_back(bus.s_data[8*i +: 8]);
            end
            if (bus.s_last) begin
               r     = ref_reg(cur_q);
               e.crc = r ^ 32'hffffffff;
               e.len = (cur_q.size() > 65535) ? 16'hffff : 16'(cur_q.size());
               e.ok  = (r == 32'hdebb20e3);
               exp_q.push_back(e);
               cur_q.delete();
            end
         end
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int waited;
      waited      = 0;
      bus.s_data  = d;
      bus.s_keep  = k;
      bus.s_last  = l;
      bus.s_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (bus.s_ready) break;
         waited++;
         if (waited > 100) begin
            check("send_timeout", 64'(0), 64'(1));
            break;
         end
         @(posedge clk); #1;
         if (rand_ready) bus.m_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] pa, pb, d;
      logic [7:0]  kp;
      int          nb;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_keep  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_m_valid", 64'(bus.m_valid), 64'(0));
      check("reset_m_crc", 64'(bus.m_crc), 64'(0));
      check("reset_m_len", 64'(bus.m_len), 64'(0));
      check("reset_s_ready", 64'(bus.s_ready), 64'(1));
`ifdef CRC_STREAM_CHECK_EN
      check("reset_m_ok", 64'(bus.m_ok), 64'(0));
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      send_beat(64'h3837363534333231, 8'hff, 1'b0);
      send_beat(64'h39, 8'h01, 1'b1);
      @(negedge clk);
      check("std_valid_latency", 64'(bus.m_valid), 64'(1));
      check("std_crc", 64'(bus.m_crc), 64'(32'hcbf43926));
      check("std_len", 64'(bus.m_len), 64'(9));

      send_beat({$urandom, $urandom}, 8'h00, 1'b1);
      @(negedge clk);
      check("empty_crc", 64'(bus.m_crc), 64'(0));
      check("empty_len", 64'(bus.m_len), 64'(0));

`ifdef CRC_STREAM_CHECK_EN
      send_beat(64'h3837363534333231, 8'hff, 1'b0);
      send_beat(64'hcbf4392639, 8'h1f, 1'b1);
      @(negedge clk);
      check("residue_ok", 64'(bus.m_ok), 64'(1));
      check("residue_len", 64'(bus.m_len), 64'(13));
      d = 64'h3837363534333231 ^ (64'h1 << $urandom_range(0, 63));
      send_beat(d, 8'hff, 1'b0);
      send_beat(64'hcbf4392639, 8'h1f, 1'b1);
      @(negedge clk);
      check("residue_flip_ok", 64'(bus.m_ok), 64'(0));
`endif

      rand_ready = 1'b1;
      for (int p = 0; p < 60; p++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk); #1;
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            kp = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
            send_beat({$urandom, $urandom}, kp, b == nb - 1);
         end
      end
      rand_ready  = 1'b0;
      bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      pa = {$urandom, $urandom};
      pb = {$urandom, $urandom};
      bus.m_ready = 1'b0;
      send_beat(pa, 8'h0f, 1'b1);
      bus.s_data  = pb;
      bus.s_keep  = 8'hff;
      bus.s_last  = 1'b1;
      bus.s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_s_ready", 64'(bus.s_ready), 64'(0));
         check("bp_m_crc", 64'(bus.m_crc), 64'(exp_crc(pa, 4)));
         @(posedge clk); #1;
      end
      bus.m_ready = 1'b1;
      @(negedge clk);
      check("bp_release_s_ready", 64'(bus.s_ready), 64'(1));
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      @(negedge clk);
      check("bp_second_valid", 64'(bus.m_valid), 64'(1));
      check("bp_second_crc", 64'(bus.m_crc), 64'(exp_crc(pb, 8)));
      check("bp_second_len", 64'(bus.m_len), 64'(8));
      @(posedge clk); #1;

      send_beat(64'h3837363534333231, 8'hff, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_m_valid", 64'(bus.m_valid), 64'(0));
      check("midrst_s_ready", 64'(bus.s_ready), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_beat(64'h3837363534333231, 8'hff, 1'b0);
      send_beat(64'h39, 8'h01, 1'b1);
      @(negedge clk);
      check("midrst_crc", 64'(bus.m_crc), 64'(32'hcbf43926));
      check("midrst_len", 64'(bus.m_len), 64'(9));

      for (int i = 0; i < 8200; i++) send_beat({$urandom, $urandom}, 8'hff, 1'b0);
      send_beat({$urandom, $urandom}, 8'hff, 1'b1);
      @(negedge clk);
      check("sat_len", 64'(bus.m_len), 64'(16'hffff));

      repeat (2) @(negedge clk);
      check("pending_results", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
